sequential_alu: RTL and testbench

//  Multi-cycle, handshaked successor to the combinational ALU.
//  - Accepts an operand pair and an op code through a valid/ready input port.
//  - Computes single-cycle ops directly and iterative ops (shifts, optional multiply) one step per clock.
//  - Presents the result and registered NZCV flags on a valid/ready output port.
//  - Sits between the register-read stage and writeback of the datapath.

---
 rtl/sequential_alu.sv | 204 ++++++++++++++++++++
 tb/tb_sequential_alu.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/sequential_alu.sv
// Handshaked multi-cycle ALU: logic/add/sub in one step, shifts one bit per clock,
// optional shift-add multiply built only when SEQ_ALU_MUL_EN is defined.
module sequential_alu #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   ALUControl,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out,
  output logic         negative,
  output logic         zero,
  output logic         carry_out,
  output logic         overflow,
  output logic         illegal_op
);
  localparam int SW = $clog2(N);
  localparam int CW = SW + 1;

  localparam logic [3:0] OP_AND = 4'b0000, OP_OR  = 4'b0001, OP_XOR  = 4'b0010, OP_NOT = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100, OP_SRL = 4'b0101, OP_SRA  = 4'b0110;
  localparam logic [3:0] OP_ADD = 4'b1000, OP_SUB = 4'b1001, OP_ADD1 = 4'b1010, OP_MUL = 4'b1100;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state_q, state_d;
  logic [3:0]    op_q, op_d, op_in;
  logic [N-1:0]  sh_q, sh_d, sh_in, sh_nx;
  logic [CW-1:0] cnt_q, cnt_d, cnt_in;
  logic [N-1:0]  res_q, res_d;
  logic          n_q, n_d, z_q, z_d, c_q, c_d, v_q, v_d, ill_q, ill_d;
  logic          accept, sh_c, is_shift_in, is_mul_in;
  logic [N-1:0]  mul_res, addb, fin_res;
  logic          mul_hi, cin, add_v, fin_c, fin_v, fin_ill;
  logic [N:0]    sum;

  assign in_ready = reset_n && (state_q == IDLE || (state_q == DONE && out_ready));
  assign accept   = in_valid && in_ready;

`ifdef SEQ_ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
  logic [2*N-1:0] acc_q, acc_d, acc_in, mcand_q, mcand_d, mcand_in;
  logic [N-1:0]   mplier_q, mplier_d, mplier_in;

  // Shift-add: retire one multiplier bit per step; the accept edge does step one.
  always_comb begin
    acc_in    = accept ? '0 : acc_q;
    mcand_in  = accept ? {{N{1'b0}}, a} : mcand_q;
    mplier_in = accept ? b : mplier_q;
    acc_d     = acc_in + (mplier_in[0] ? mcand_in : '0);
    mcand_d   = mcand_in << 1;
    mplier_d  = mplier_in >> 1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else if (accept || state_q == BUSY) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

  assign mul_res = acc_d[N-1:0];
  assign mul_hi  = |acc_d[2*N-1:N];
`else
  localparam bit MUL_EN = 1'b0;
  assign mul_res = '0;
  assign mul_hi  = 1'b0;
`endif

  // Accept-edge values come straight from the ports; later steps from the working regs.
  always_comb begin
    op_in       = accept ? ALUControl : op_q;
    sh_in       = accept ? a : sh_q;
    is_mul_in   = MUL_EN && (op_in == OP_MUL);
    is_shift_in = (op_in == OP_SLL) || (op_in == OP_SRL) || (op_in == OP_SRA);
    if (accept) cnt_in = (ALUControl == OP_MUL) ? CW'(N) : CW'(b[SW-1:0]);
    else        cnt_in = cnt_q;
  end

  always_comb begin
    sh_c  = 1'b0;
    sh_nx = sh_in;
    case (op_in[1:0])
      2'b00:   begin sh_c = sh_in[N-1]; sh_nx = {sh_in[N-2:0], 1'b0}; end
      2'b01:   begin sh_c = sh_in[0];   sh_nx = {1'b0, sh_in[N-1:1]}; end
      2'b10:   begin sh_c = sh_in[0];   sh_nx = {sh_in[N-1], sh_in[N-1:1]}; end
      default: ;
    endcase
  end

  // SUB is a + ~b + 1, so C is the no-borrow flag and V uses the inverted b sign.
  always_comb begin
    addb  = (ALUControl == OP_SUB) ? ~b : b;
    cin   = (ALUControl == OP_SUB) || (ALUControl == OP_ADD1);
    sum   = {1'b0, a} + {1'b0, addb} + {{N{1'b0}}, cin};
    add_v = (a[N-1] == addb[N-1]) && (sum[N-1] != a[N-1]);
  end

  always_comb begin
    fin_res = '0;
    fin_c   = 1'b0;
    fin_v   = 1'b0;
    fin_ill = 1'b0;
    case (op_in)
      OP_AND: fin_res = a & b;
      OP_OR:  fin_res = a | b;
      OP_XOR: fin_res = a ^ b;
      OP_NOT: fin_res = ~a;
      OP_SLL, OP_SRL, OP_SRA: begin
        if (cnt_in == '0) fin_res = sh_in;
        else begin
          fin_res = sh_nx;
          fin_c   = sh_c;
        end
      end
      OP_ADD, OP_SUB, OP_ADD1: begin
        fin_res = sum[N-1:0];
        fin_c   = sum[N];
        fin_v   = add_v;
      end
      OP_MUL: begin
        fin_res = mul_res;
        fin_c   = mul_hi;
        fin_ill = !MUL_EN;
      end
      default: fin_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    n_d     = n_q;
    z_d     = z_q;
    c_d     = c_q;
    v_d     = v_q;
    ill_d   = ill_q;
    if (accept || state_q == BUSY) begin
      op_d  = op_in;
      sh_d  = sh_nx;
      cnt_d = cnt_in - CW'(1);
      if ((is_shift_in || is_mul_in) && cnt_in > CW'(1)) begin
        state_d = BUSY;
      end else begin
        state_d = DONE;
        res_d   = fin_res;
        n_d     = op_in[3] && fin_res[N-1];
        z_d     = (fin_res == '0);
        c_d     = fin_c;
        v_d     = fin_v;
        ill_d   = fin_ill;
      end
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      sh_q    <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      n_q     <= n_d;
      z_q     <= z_d;
      c_q     <= c_d;
      v_q     <= v_d;
      ill_q   <= ill_d;
    end
  end

  assign out_valid  = (state_q == DONE);
  assign out        = res_q;
  assign negative   = n_q;
  assign zero       = z_q;
  assign carry_out  = c_q;
  assign overflow   = v_q;
  assign illegal_op = ill_q;
endmodule

// File: tb/tb_sequential_alu.sv
// Scoreboard bench for sequential_alu (N=8): driver pushes expected results,
// a negedge monitor compares every presented result, its latency, and hold stability.
module tb_sequential_alu;
  logic       clk = 1'b0, reset_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [7:0] a = '0, b = '0, out;
  logic [3:0] op = '0;
  logic       in_ready, out_valid, negative, zero, carry_out, overflow, illegal_op;

  sequential_alu #(.N(8)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ALUControl(op), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .negative(negative), .zero(zero), .carry_out(carry_out),
    .overflow(overflow), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // f = {N, Z, C, V, illegal}
  typedef struct {string nm; logic [7:0] r; logic [4:0] f; int lat; int acc;} exp_t;
  exp_t q[$];
  exp_t e;
  int   total = 0, bad = 0;
  bit   new_res = 1'b1;

  localparam logic [3:0] AND_ = 4'b0000, OR_ = 4'b0001, XOR_ = 4'b0010, NOT_ = 4'b0011;
  localparam logic [3:0] SLL = 4'b0100, SRL = 4'b0101, SRA = 4'b0110;
  localparam logic [3:0] ADD = 4'b1000, SUB = 4'b1001, ADD1 = 4'b1010, MUL = 4'b1100;

  task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      q.delete();
      new_res = 1'b1;
    end else if (out_valid) begin
      if (q.size() == 0) chk("stale_out_valid", 32'(out_valid), 0);
      else begin
        e = q[0];
        chk({e.nm, "_out"}, 32'(out), 32'(e.r));
        chk({e.nm, "_flags"}, 32'({negative, zero, carry_out, overflow, illegal_op}), 32'(e.f));
        if (new_res) chk({e.nm, "_lat"}, 32'(cyc - e.acc + 1), 32'(e.lat));
        new_res = 1'b0;
        if (out_ready) begin
          void'(q.pop_front());
          new_res = 1'b1;
        end
      end
    end
  end

  // Called just after a posedge; returns just after the accept edge.
  task automatic issue(string nm, logic [3:0] o, logic [7:0] ia, logic [7:0] ib,
                       logic [7:0] r, logic [4:0] f, int lat, output int waited);
    exp_t x;
    op = o; a = ia; b = ib; in_valid = 1'b1; waited = 0;
    #1;
    while (!in_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) chk({nm, "_accept_timeout"}, 32'(in_ready), 1);
    else begin
      x = '{nm, r, f, lat, cyc + 1};
      q.push_back(x);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(string nm);
    int n = 0;
    while (q.size() != 0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_drain"}, 32'(q.size()), 0);
  endtask

  task automatic run1(string nm, logic [3:0] o, logic [7:0] ia, logic [7:0] ib,
                      logic [7:0] r, logic [4:0] f, int lat);
    int w;
    issue(nm, o, ia, ib, r, f, lat, w);
    drain(nm);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d want=finished", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int w;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out", 32'(out), 0);
    chk("rst_flags", 32'({negative, zero, carry_out, overflow, illegal_op}), 0);
    reset_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;

    run1("add_ovf",  ADD,  8'h7F, 8'h01, 8'h80, 5'b10010, 1);
    run1("sub_eq",   SUB,  8'h05, 8'h05, 8'h00, 5'b01100, 1);
    run1("sub_neg",  SUB,  8'h03, 8'h05, 8'hFE, 5'b10000, 1);

    issue("sll3", SLL, 8'h81, 8'h03, 8'h08, 5'b00000, 3, w);
    chk("sll3_busy_rdy1", 32'(in_ready), 0);
    @(posedge clk); #1;
    chk("sll3_busy_rdy2", 32'(in_ready), 0);
    drain("sll3");
    run1("sra2",     SRA,  8'h90, 8'h02, 8'hE4, 5'b00000, 2);
    run1("srl1",     SRL,  8'h81, 8'h01, 8'h40, 5'b00100, 1);
    run1("srl2_z",   SRL,  8'h03, 8'h02, 8'h00, 5'b01100, 2);
    run1("sll_wrap0",SLL,  8'h55, 8'h08, 8'h55, 5'b00000, 1);
    run1("sra7",     SRA,  8'h80, 8'h07, 8'hFF, 5'b00000, 7);
    run1("and",      AND_, 8'hF0, 8'h3C, 8'h30, 5'b00000, 1);
    run1("or",       OR_,  8'hF0, 8'h0F, 8'hFF, 5'b00000, 1);
    run1("not",      NOT_, 8'h0F, 8'h77, 8'hF0, 5'b00000, 1);
    run1("add1",     ADD1, 8'hFF, 8'h00, 8'h00, 5'b01100, 1);
    run1("add_cv",   ADD,  8'h80, 8'h80, 8'h00, 5'b01110, 1);
    run1("sub_v",    SUB,  8'h80, 8'h01, 8'h7F, 5'b00110, 1);
    run1("ill_0111", 4'b0111, 8'h12, 8'h34, 8'h00, 5'b01001, 1);
    run1("ill_1111", 4'b1111, 8'hFF, 8'hFF, 8'h00, 5'b01001, 1);
`ifdef SEQ_ALU_MUL_EN
    run1("mul_a",    MUL,  8'h10, 8'h11, 8'h10, 5'b00100, 8);
    run1("mul_b",    MUL,  8'h0F, 8'h0F, 8'hE1, 5'b10000, 8);
    run1("mul_z",    MUL,  8'hFF, 8'h00, 8'h00, 5'b01000, 8);
`else
    run1("mul_a",    MUL,  8'h10, 8'h11, 8'h00, 5'b01001, 1);
    run1("mul_b",    MUL,  8'h0F, 8'h0F, 8'h00, 5'b01001, 1);
`endif

    // Hold result under back-pressure, then accept a new op in the handshake cycle.
    out_ready = 1'b0;
    issue("hold_add", ADD, 8'h01, 8'h01, 8'h02, 5'b00000, 1, w);
    for (int i = 0; i < 5; i++) begin
      chk("hold_in_ready", 32'(in_ready), 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    issue("b2b_xor", XOR_, 8'hAA, 8'hAA, 8'h00, 5'b01000, 1, w);
    chk("b2b_wait", 32'(w), 0);
    drain("b2b_xor");

    // Reset on cycle 2 of a 5-step shift: no result may ever appear.
    issue("rst_sll", SLL, 8'h01, 8'h05, 8'h20, 5'b00000, 5, w);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_in_ready", 32'(in_ready), 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
    chk("postrst_in_ready", 32'(in_ready), 1);
    chk("postrst_q_empty", 32'(q.size()), 0);
    repeat (10) @(posedge clk);
    #1;
    run1("postrst_and", AND_, 8'hC3, 8'h0F, 8'h03, 5'b00000, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
